// File: rtl/multiport_regfile.sv
// Multi-read, dual-write register file with a per-register pending scoreboard.
// Reads are combinational with optional same-cycle write forwarding.
module multiport_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pendingNext;

    logic waLive;
    logic wbLive;
    logic allocLive;

    // A port is live only outside reset and, with a hardwired r0, never for address 0
    always_comb begin
        waLive    = wa_en    && !rst && !((ZERO_REG != 0) && (wa_addr    == '0));
        wbLive    = wb_en    && !rst && !((ZERO_REG != 0) && (wb_addr    == '0));
        allocLive = alloc_en && !rst && !((ZERO_REG != 0) && (alloc_addr == '0));
    end

    // Writes clear the pending bit; a same-cycle alloc overrides the clear
    always_comb begin
        pendingNext = pending;
        if (wbLive) begin
            pendingNext[wb_addr] = 1'b0;
        end
        if (waLive) begin
            pendingNext[wa_addr] = 1'b0;
        end
        if (allocLive) begin
            pendingNext[alloc_addr] = 1'b1;
        end
    end

    // Port A is applied after port B so it wins on an address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (wbLive) begin
                regs[wb_addr] <= wb_data;
            end
            if (waLive) begin
                regs[wa_addr] <= wa_data;
            end
            pending <= pendingNext;
        end
    end

    for (genvar g = 0; g < int'(NUM_RD); g++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign addr = rd_addr[g*ADDR_W +: ADDR_W];

        // Forwarding order B then A gives A priority; the zero register overrides all
        always_comb begin
            data = regs[addr];
            pend = pending[addr];
            if (BYPASS != 0) begin
                if (wbLive && (wb_addr == addr)) begin
                    data = wb_data;
                    pend = 1'b0;
                end
                if (waLive && (wa_addr == addr)) begin
                    data = wa_data;
                    pend = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = data;
        assign rd_pend[g]                  = pend;
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed, table-driven check of multiport_regfile with default parameters.
module tb_multiport_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;

    int total = 0;
    int bad   = 0;

    multiport_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_pend   (rd_pend),
        .wa_en     (wa_en),
        .wa_addr   (wa_addr),
        .wa_data   (wa_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        waEn;
        logic [4:0]  waAddr;
        logic [31:0] waData;
        logic        wbEn;
        logic [4:0]  wbAddr;
        logic [31:0] wbData;
        logic        allocEn;
        logic [4:0]  allocAddr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] expD0;
        logic [31:0] expD1;
        logic        expP0;
        logic        expP1;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst      = 1'b0;
        wa_en    = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en    = 1'b0; wb_addr = '0; wb_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    // Inputs change at negedge; outputs are sampled 1ns later, before the next rising edge
    task automatic applyVec(input int idx, input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        wa_en    = v.waEn;    wa_addr = v.waAddr; wa_data = v.waData;
        wb_en    = v.wbEn;    wb_addr = v.wbAddr; wb_data = v.wbData;
        alloc_en = v.allocEn; alloc_addr = v.allocAddr;
        rd_addr  = {v.ra1, v.ra0};
        #1;
        check($sformatf("v%0d.d0", idx), rd_data[31:0],  v.expD0);
        check($sformatf("v%0d.d1", idx), rd_data[63:32], v.expD1);
        check($sformatf("v%0d.p0", idx), 32'(rd_pend[0]), 32'(v.expP0));
        check($sformatf("v%0d.p1", idx), 32'(rd_pend[1]), 32'(v.expP1));
    endtask

    initial begin
        //           rst   waEn  waAddr waData         wbEn  wbAddr wbData        alEn  alAddr ra0   ra1   expD0          expD1          p0    p1
        vecs[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5, 5'd3, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hABCDE123,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5, 5'd3, 32'hABCDE123,  32'h0,         1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5, 5'd3, 32'hABCDE123,  32'h0,         1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 5'd7,  32'h11111111,  1'b1, 5'd7,  32'h22222222, 1'b0, 5'd0,  5'd7, 5'd7, 32'h11111111,  32'h11111111,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7, 5'd7, 32'h11111111,  32'h11111111,  1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF,  1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0, 5'd5, 32'h0,         32'hABCDE123,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9, 5'd9, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9, 5'd5, 32'h0,         32'hABCDE123,  1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  32'h5A5A5A5A, 1'b0, 5'd0,  5'd9, 5'd9, 32'h5A5A5A5A,  32'h5A5A5A5A,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9, 5'd9, 32'h5A5A5A5A,  32'h5A5A5A5A,  1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 5'd9,  32'h12345678,  1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9, 5'd2, 32'h12345678,  32'h0,         1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9, 5'd9, 32'h12345678,  32'h12345678,  1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  32'h33333333, 1'b0, 5'd0,  5'd3, 5'd4, 32'h33333333,  32'h0,         1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3, 5'd7, 32'h33333333,  32'h11111111,  1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 5'd6,  32'h0000000A,  1'b1, 5'd8,  32'h0000000B, 1'b0, 5'd0,  5'd8, 5'd6, 32'h0000000B,  32'h0000000A,  1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd6, 5'd8, 32'h0000000A,  32'h0000000B,  1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 5'd10, 32'hDEADBEEF,  1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 5'd10, 5'd9, 32'h0,        32'h12345678,  1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd10, 5'd9, 32'h0,        32'h0,         1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd11, 5'd5, 32'h0,        32'h0,         1'b0, 1'b0};

        idle();
        rd_addr = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyVec(i, vecs[i]);
        end

        // Fill r1..r31 with distinct values; alloc r4 alongside the last write
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            idle();
            wa_en   = 1'b1;
            wa_addr = 5'(i);
            wa_data = 32'h5000_0000 + 32'(i) * 32'h0101_0101;
            if (i == 31) begin
                alloc_en   = 1'b1;
                alloc_addr = 5'd4;
            end
        end
        @(negedge clk);
        idle();
        for (int i = 1; i < 32; i += 2) begin
            rd_addr = {5'(i + 1), 5'(i)};
            #1;
            check($sformatf("fill.r%0d", i), rd_data[31:0], 32'h5000_0000 + 32'(i) * 32'h0101_0101);
        end
        rd_addr = {5'd4, 5'd4};
        #1;
        check("fill.pend4.p0", 32'(rd_pend[0]), 32'd1);
        check("fill.pend4.p1", 32'(rd_pend[1]), 32'd1);

        // Reset with a write and alloc in flight; nothing from that cycle survives
        @(negedge clk);
        rst        = 1'b1;
        wa_en      = 1'b1; wa_addr = 5'd12; wa_data = 32'hFFFF_FFFF;
        wb_en      = 1'b1; wb_addr = 5'd13; wb_data = 32'hEEEE_EEEE;
        alloc_en   = 1'b1; alloc_addr = 5'd14;
        @(negedge clk);
        idle();
        for (int i = 0; i < 32; i += 2) begin
            rd_addr = {5'(i + 1), 5'(i)};
            #1;
            check($sformatf("rst.d.r%0d", i),     rd_data[31:0],  32'h0);
            check($sformatf("rst.d.r%0d", i + 1), rd_data[63:32], 32'h0);
            check($sformatf("rst.p.r%0d", i),     32'(rd_pend[0]), 32'd0);
            check($sformatf("rst.p.r%0d", i + 1), 32'(rd_pend[1]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
